// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//
// Shared definitions for the 32x32 register file slice.
//
//   DATA_WIDTH  width of one register and of every data port (32)
//   ADDR_WIDTH  width of every address port (5)
//   DEPTH       number of registers, always 2**ADDR_WIDTH (32)
//
//   rf_data_t   one register word
//   rf_addr_t   one register address
//   rf_op_t     operation decoded from the {READ, WRITE} strobe pair
//   decode_op   helper turning the two strobes into an rf_op_t
//
// Optional feature macro used by the files importing this package:
//   RF_ZERO_REG_EN  register 0 is hardwired to zero
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 32;

    typedef logic [DATA_WIDTH-1:0] rf_data_t;
    typedef logic [ADDR_WIDTH-1:0] rf_addr_t;

    // Encodings are pinned to the {READ, WRITE} bit pair so that the enum
    // value and the raw strobes can be compared at a glance in a waveform.
    typedef enum logic [1:0] {
        RF_NOP     = 2'b00,
        RF_RD      = 2'b10,
        RF_WR      = 2'b01,
        RF_ILLEGAL = 2'b11
    } rf_op_t;

    // Both strobes high is not a legal request; it is reported as its own
    // operation so that every consumer treats it as "do nothing".
    function automatic rf_op_t decode_op(input logic read, input logic write);
        rf_op_t op;
        case ({read, write})
            2'b00:   op = RF_NOP;
            2'b10:   op = RF_RD;
            2'b01:   op = RF_WR;
            default: op = RF_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
//
// One registered read port of the register file: selects a word out of the
// flattened storage vector and captures it into the output register when
// load_en is high. Between loads the output holds its last value.
//
// Ports:
//   CLK      input   1                     system clock, rising edge
//   RST      input   1                     synchronous active-high reset
//   load_en  input   1                     capture the selected word this edge
//   rd_addr  input   ADDR_WIDTH            register to read
//   storage  input   DEPTH*DATA_WIDTH      all registers, register i at
//                                          bits [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_data  output  DATA_WIDTH            registered read data
//
// Optional feature: RF_ZERO_REG_EN - address 0 always reads as zero.
// -----------------------------------------------------------------------------
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int DEPTH      = rf_pkg::DEPTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        load_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [DEPTH*DATA_WIDTH-1:0] storage,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    logic [DATA_WIDTH-1:0] sel_word;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here the unconditional first assignment), otherwise a latch is inferred.
    always_comb begin
        sel_word = storage[rd_addr*DATA_WIDTH +: DATA_WIDTH];
`ifdef RF_ZERO_REG_EN
        // Register 0 is never written in this build, but forcing the mux
        // result keeps the read path independent of the storage contents.
        if (rd_addr == '0) begin
            sel_word = '0;
        end
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= '0;
        end else if (load_en) begin
            rd_data <= sel_word;
        end
    end

endmodule : rf_read_port

// File: rtl/register_file_32x32.sv
// -----------------------------------------------------------------------------
// register_file_32x32
//
// 32-entry x 32-bit general-purpose register file with two registered read
// ports and one write port. A single strobe pair selects the operation each
// cycle:
//   READ=0 WRITE=0  no-op, everything holds
//   READ=1 WRITE=0  both read ports load mem[ADDR_R1] / mem[ADDR_R2]
//   READ=0 WRITE=1  mem[ADDR_W] <= DATA_W, read outputs hold
//   READ=1 WRITE=1  illegal, treated as no-op
// Reads and writes never share a cycle, so there is no write-to-read bypass.
// RST clears storage and both outputs and overrides any strobe.
//
// Ports:
//   CLK      input   1           system clock, rising edge
//   RST      input   1           synchronous active-high reset
//   READ     input   1           read strobe
//   WRITE    input   1           write strobe
//   ADDR_R1  input   ADDR_WIDTH  read port 1 address
//   ADDR_R2  input   ADDR_WIDTH  read port 2 address
//   ADDR_W   input   ADDR_WIDTH  write address
//   DATA_W   input   DATA_WIDTH  write data
//   DATA_R1  output  DATA_WIDTH  read port 1 data, registered
//   DATA_R2  output  DATA_WIDTH  read port 2 data, registered
//
// Optional feature macro:
//   RF_ZERO_REG_EN  register 0 hardwired to zero; writes to address 0 are
//                   dropped and reads of address 0 return 0 on both ports.
//                   Undefined (default): register 0 is an ordinary register.
// -----------------------------------------------------------------------------
module register_file_32x32
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int DEPTH      = rf_pkg::DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    rf_op_t op;
    logic   rd_load;
    logic   wr_en;

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*DATA_WIDTH-1:0] storage_flat;

    // -------------------------------------------------------------------------
    // Operation decode
    // -------------------------------------------------------------------------
    assign op      = decode_op(READ, WRITE);
    assign rd_load = (op == RF_RD);

`ifdef RF_ZERO_REG_EN
    assign wr_en = (op == RF_WR) && (ADDR_W != '0);
`else
    assign wr_en = (op == RF_WR);
`endif

    // -------------------------------------------------------------------------
    // Storage array and write port
    // -------------------------------------------------------------------------
    // NOTE: the array is cleared on reset because architecturally visible
    // state must read 0 afterwards; this forces flops rather than a RAM macro,
    // which is acceptable at 32 entries.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[ADDR_W] <= DATA_W;
        end
    end

    // Flatten the array so each read port sees a plain vector.
    for (genvar g = 0; g < DEPTH; g++) begin : g_flatten
        assign storage_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port_r1 (
        .CLK     (CLK),
        .RST     (RST),
        .load_en (rd_load),
        .rd_addr (ADDR_R1),
        .storage (storage_flat),
        .rd_data (DATA_R1)
    );

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port_r2 (
        .CLK     (CLK),
        .RST     (RST),
        .load_en (rd_load),
        .rd_addr (ADDR_R2),
        .storage (storage_flat),
        .rd_data (DATA_R2)
    );

endmodule : register_file_32x32

// File: tb/tb_register_file_32x32.sv
// -----------------------------------------------------------------------------
// tb_register_file_32x32
//
// Directed self-checking bench for register_file_32x32. Inputs are driven on
// the falling edge, the DUT samples on the rising edge and outputs are
// checked 1 ns after it. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_register_file_32x32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        READ;
    logic        WRITE;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    register_file_32x32 dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Apply one set of inputs for exactly one rising edge, then return 1 ns
    // after that edge with the strobes already dropped for the next cycle.
    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [31:0] dw);
        @(negedge CLK);
        RST = rst; READ = rd; WRITE = wr;
        ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
        @(posedge CLK);
        #1;
        RST = 1'b0; READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, a, d);
    endtask

    task automatic nop();
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [31:0] e1,
                            input logic [31:0] e2);
        cycle(1'b0, 1'b1, 1'b0, a1, a2, 5'd0, 32'h0);
        check({tag, "_r1"}, DATA_R1, e1);
        check({tag, "_r2"}, DATA_R2, e2);
    endtask

    initial begin
        RST = 1'b0; READ = 1'b0; WRITE = 1'b0;
        ADDR_R1 = '0; ADDR_R2 = '0; ADDR_W = '0; DATA_W = '0;

        // Reset then read all.
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        check("reset_r1", DATA_R1, 32'h0000_0000);
        check("reset_r2", DATA_R2, 32'h0000_0000);
        for (int i = 0; i < 32; i++) begin
            rd_check($sformatf("rst_rd%0d", i), 5'(i), 5'(i), 32'h0, 32'h0);
        end

        // Write/readback sweep: register i holds i. Register 0 holds 0 with
        // or without the hardwired-zero option, so the expectation is shared.
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 32'(i));
        end
        nop();
        for (int i = 0; i < 32; i++) begin
            rd_check($sformatf("sweep%0d", i), 5'(i), 5'(i), 32'(i), 32'(i));
        end

        // Dual-port independence.
        rd_check("dual", 5'd5, 5'd26, 32'h0000_0005, 32'h0000_001A);

        // Hold / illegal strobe combination.
        wr(5'd7, 32'hDEAD_BEEF);
        rd_check("dead_rd", 5'd7, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        // Read addresses differ from 7 so an illegal cycle acting as a read
        // would change the outputs.
        cycle(1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd7, 32'h1234_5678);
        check("illegal_r1", DATA_R1, 32'hDEAD_BEEF);
        check("illegal_r2", DATA_R2, 32'hDEAD_BEEF);
        nop();
        check("nop_r1", DATA_R1, 32'hDEAD_BEEF);
        check("nop_r2", DATA_R2, 32'hDEAD_BEEF);
        rd_check("dead_again", 5'd7, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // A write does not disturb the registered outputs.
        rd_check("r3", 5'd3, 5'd3, 32'h0000_0003, 32'h0000_0003);
        wr(5'd3, 32'hFFFF_FFFF);
        check("wr_hold_r1", DATA_R1, 32'h0000_0003);
        check("wr_hold_r2", DATA_R2, 32'h0000_0003);
        rd_check("r3_new", 5'd3, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Reset mid-operation with a concurrent write.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'hA5A5_0000 | 32'(i));
        end
        rd_check("fill", 5'd10, 5'd31, 32'hA5A5_000A, 32'hA5A5_001F);
        cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'hCAFE_F00D);
        check("midrst_r1", DATA_R1, 32'h0000_0000);
        check("midrst_r2", DATA_R2, 32'h0000_0000);
        for (int i = 0; i < 32; i++) begin
            rd_check($sformatf("midrst_rd%0d", i), 5'(i), 5'(31 - i),
                     32'h0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_file_32x32
